ssd_page_scanner: RTL and testbench
===================================

// Module: ssd_page_scanner
// PURPOSE
//  Parametrised seven-segment scan controller for the Nexys4 8-digit display.
//  Takes N_PAGES of packed hex values (e.g. score, power, angle), each N_DIGITS nibbles wide.
//  Shows one page at a time; a debounced button cycles through the pages.
//  Adds tear-free snapshotting, leading-zero blanking, per-digit DP and an anti-ghost guard.
//  Sits between the game logic and the An*/Ca..Cg/Dp pins in the top level.
// PARAMETERS
//  N_DIGITS     8        digits scanned (1..8)
//  N_PAGES      3        selectable pages (1..8)
//  SLOT_CYCLES  131072   clk cycles per digit slot (>= GUARD_CYCLES+2)
//  GUARD_CYCLES 256      cycles at slot start with all anodes off
//  DEB_CYCLES   1000000  cycles the synced button must be stable before acceptance
// PORTS
//  clk        in   1                 system clock, 100 MHz
//  rst_n      in   1                 asynchronous active-low reset
//  page_data  in   N_PAGES*N_DIGITS*4  page p, digit d = bits [(p*N_DIGITS+d)*4 +: 4]; d=0 rightmost
//  btn_page   in   1                 raw, asynchronous page-advance button
//  blank_lz   in   1                 1 = blank leading zeros
//  dp_mask    in   N_DIGITS          1 = light the decimal point of digit d
//  anode      out  N_DIGITS          active-low digit enables
//  ssd_out    out  7                 active-low segments {a,b,c,d,e,f,g}
//  dp         out  1                 active-low decimal point
//  page_sel   out  clog2(N_PAGES)    currently shown page (min width 1)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - anode all 1; ssd_out 7'h7F; dp 1; page_sel 0.
//   - slot counter 0, digit index 0, snapshot 0, debounce state 0.
//   - Outputs are registered and change only on posedge clk after release.
//  Scan:
//   - slot_cnt counts 0..SLOT_CYCLES-1. At wrap, digit index advances 0..N_DIGITS-1, then back to 0.
//   - Guard: while slot_cnt < GUARD_CYCLES, all anodes are 1. Otherwise exactly one anode (index) is 0.
//  Snapshot:
//   - On the cycle the digit index wraps N_DIGITS-1 -> 0, and on the first cycle after reset, the selected page is copied into a snapshot register.
//   - All decoding uses the snapshot only, so a value changing mid-scan never tears.
//  Decoding:
//   - Full hex font 0-F, active-low. Example: 0 = 7'h01, 1 = 7'h4F, 8 = 7'h00, F = 7'h38.
//   - Leading-zero blank (blank_lz=1): digit d blanks (ssd_out = 7'h7F) if it and every higher digit are 0.
//   - Digit 0 is never blanked, so all-zero shows a single "0".
//   - A blanked digit still drives its anode low.
//   - dp = ~dp_mask[index] during the active part of the slot; dp = 1 during the guard.
//  Button:
//   - 2-flop synchroniser feeds a stability counter.
//   - The debounced level changes only after DEB_CYCLES consecutive identical synced samples.
//   - Any mismatch clears the counter.
//   - A debounced 0->1 edge increments page_sel one cycle later. It wraps N_PAGES-1 -> 0.
//   - A release (1->0) has no effect. Holding the button gives exactly one advance.
//   - The new page appears at the next scan-start snapshot; page_sel updates immediately.
//  Edge cases:
//   - N_PAGES=1: page_sel stays 0 and presses are ignored.
//   - Reset mid-scan or mid-debounce: everything returns to reset values at once.
//   - A press and a snapshot in the same cycle: the snapshot takes the old page; the next scan shows the new one.
// TESTING  (N_DIGITS=4, N_PAGES=3, SLOT_CYCLES=8, GUARD_CYCLES=2, DEB_CYCLES=4)
//  1 Reset: hold rst_n=0 -> anode=4'hF, ssd_out=7'h7F, dp=1, page_sel=0.
//    Release -> slot0 cycles 0-1 anode=F; cycles 2-7 anode=4'hE; then 4'hD, 4'hB, 4'h7; repeat every 32 cycles.
//  2 Page 0 = 16'h12AF, blank_lz=0, dp_mask=4'b0100 -> per slot ssd_out = F(7'h38), A(7'h08), 2(7'h12), 1(7'h4F).
//    dp=0 only in the slot with anode=4'hB.
//  3 Page 0 = 16'h0030, blank_lz=1 -> digits 3,2 show 7'h7F with anodes still pulsing; digit 1 shows 3(7'h06); digit 0 shows 0(7'h01).
//    Set 16'h0000 -> only digit 0 is lit with "0".
//  4 Debounce: 3-cycle glitch on btn_page -> page_sel unchanged.
//    Hold 20 cycles -> page_sel 0->1 once.
//    Three clean presses from 1 -> page_sel 2, 0, 1 (wrap).
//  5 Tear-free: change page_data while the digit index is 2 -> displayed digits unchanged until the index returns to 0.
//    After that, the new values appear.
//  6 Assert rst_n=0 mid-slot with page_sel=2 -> outputs return to reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/ssd_page_scanner.sv
// ssd_page_scanner
//   Multiplexed seven-segment scan controller for the Nexys4 8-digit display.
//   Several packed hex "pages" (score, power, angle, ...) are offered in
//   parallel. One page is shown at a time, and a debounced push-button steps
//   through them. The shown page is latched once per full scan, so the value
//   cannot tear while it is being scanned. Leading zeros can be blanked. Each
//   digit has its own decimal point. A short all-anodes-off guard at the start
//   of every digit slot stops the previous digit from ghosting into the next.
//
// Ports
//   clk        in   system clock (100 MHz)
//   rst_n      in   asynchronous active-low reset
//   page_data  in   page p, digit d = bits [(p*N_DIGITS+d)*4 +: 4], d=0 rightmost
//   btn_page   in   raw asynchronous page-advance button
//   blank_lz   in   1 = blank leading zeros (digit 0 is never blanked)
//   dp_mask    in   1 = light decimal point of digit d
//   anode      out  active-low digit enables
//   ssd_out    out  active-low segments {a,b,c,d,e,f,g}
//   dp         out  active-low decimal point
//   page_sel   out  page currently selected
//
// All display outputs are registered. They are decoded from the *next* scan
// position, so anode/ssd_out/dp line up with the slot counter that is
// visible in the same cycle.
module ssd_page_scanner #(
  parameter int N_DIGITS     = 8,
  parameter int N_PAGES      = 3,
  parameter int SLOT_CYCLES  = 131072,
  parameter int GUARD_CYCLES = 256,
  parameter int DEB_CYCLES   = 1000000
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [N_PAGES*N_DIGITS*4-1:0]                     page_data,
  input  logic                                              btn_page,
  input  logic                                              blank_lz,
  input  logic [N_DIGITS-1:0]                               dp_mask,
  output logic [N_DIGITS-1:0]                               anode,
  output logic [6:0]                                        ssd_out,
  output logic                                              dp,
  output logic [((N_PAGES > 1) ? $clog2(N_PAGES) : 1)-1:0]  page_sel
);

  localparam int PW     = (N_PAGES > 1) ? $clog2(N_PAGES) : 1;
  localparam int IW     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SW     = $clog2(SLOT_CYCLES);
  localparam int DW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PAGE_W = N_DIGITS * 4;

  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] GUARD_LIM = SW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [PW-1:0] PAGE_LAST = PW'(N_PAGES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

  // Scan state
  logic [SW-1:0]     slotCnt;
  logic [IW-1:0]     digitIdx;
  logic [PAGE_W-1:0] snap;
  logic              firstCycle;

  // Button state
  logic              btnMeta;
  logic              btnSync;
  logic              debLevel;
  logic [DW-1:0]     debCnt;
  logic              advPulse;
  logic [PW-1:0]     pageSel;

  // Next-state / decode signals
  logic              slotWrap;
  logic              scanWrap;
  logic [SW-1:0]     slotNext;
  logic [IW-1:0]     idxNext;
  logic              guardNext;
  logic [PAGE_W-1:0] selPage;
  logic [PAGE_W-1:0] snapNext;
  logic [3:0]        curNib;
  logic              curBlank;
  logic              curDp;
  logic              zeroRun;
  logic [N_DIGITS-1:0] anodeNext;
  logic [6:0]        segNext;
  logic              dpNext;

  function automatic logic [6:0] hexFont(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h01;
      4'h1:    seg = 7'h4F;
      4'h2:    seg = 7'h12;
      4'h3:    seg = 7'h06;
      4'h4:    seg = 7'h4C;
      4'h5:    seg = 7'h24;
      4'h6:    seg = 7'h20;
      4'h7:    seg = 7'h0F;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h04;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h60;
      4'hC:    seg = 7'h31;
      4'hD:    seg = 7'h42;
      4'hE:    seg = 7'h30;
      default: seg = 7'h38;
    endcase
    return seg;
  endfunction

  // Slot / digit sequencing
  always_comb begin
    slotWrap = (slotCnt == SLOT_LAST);
    slotNext = slotWrap ? '0 : slotCnt + SW'(1);
    scanWrap = slotWrap && (digitIdx == IDX_LAST);
    if (!slotWrap)
      idxNext = digitIdx;
    else if (digitIdx == IDX_LAST)
      idxNext = '0;
    else
      idxNext = digitIdx + IW'(1);
    guardNext = (slotNext < GUARD_LIM);
  end

  // Page multiplexer
  always_comb begin
    selPage = '0;
    for (int p = 0; p < N_PAGES; p++) begin
      if (pageSel == PW'(p))
        selPage = page_data[p*PAGE_W +: PAGE_W];
    end
  end

  // The snapshot reloads when the scan restarts at digit 0. It also reloads
  // once right after reset, so the first scan does not show zeros. It reads
  // the registered pageSel. So a press that lands on the reload cycle still
  // gets the old page, and the new page appears on the following scan.
  assign snapNext = (firstCycle || scanWrap) ? selPage : snap;

  // Digit select with leading-zero detection. The loop walks from the most
  // significant digit down, so zeroRun means "this digit and all digits
  // above it are zero".
  always_comb begin
    curNib   = 4'h0;
    curBlank = 1'b0;
    curDp    = 1'b0;
    zeroRun  = 1'b1;
    for (int d = N_DIGITS - 1; d >= 0; d--) begin
      zeroRun = zeroRun && (snapNext[d*4 +: 4] == 4'h0);
      if (idxNext == IW'(d)) begin
        curNib   = snapNext[d*4 +: 4];
        curBlank = blank_lz && zeroRun && (d != 0);
        curDp    = dp_mask[d];
      end
    end
  end

  // Output decode. A blanked digit still gets its anode driven.
  always_comb begin
    for (int d = 0; d < N_DIGITS; d++)
      anodeNext[d] = guardNext || (idxNext != IW'(d));
    segNext = (guardNext || curBlank) ? 7'h7F : hexFont(curNib);
    dpNext  = guardNext ? 1'b1 : ~curDp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotCnt    <= '0;
      digitIdx   <= '0;
      snap       <= '0;
      firstCycle <= 1'b1;
      anode      <= '1;
      ssd_out    <= 7'h7F;
      dp         <= 1'b1;
    end else begin
      slotCnt    <= slotNext;
      digitIdx   <= idxNext;
      snap       <= snapNext;
      firstCycle <= 1'b0;
      anode      <= anodeNext;
      ssd_out    <= segNext;
      dp         <= dpNext;
    end
  end

  // Button: 2-flop synchroniser, then a stability counter. The counter runs
  // only while the synced level differs from the accepted level. It resets
  // on any sample that agrees with the accepted level. Only an accepted
  // rising level raises the advance pulse, so a release or a long hold
  // adds nothing more.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btnMeta  <= 1'b0;
      btnSync  <= 1'b0;
      debLevel <= 1'b0;
      debCnt   <= '0;
      advPulse <= 1'b0;
    end else begin
      btnMeta  <= btn_page;
      btnSync  <= btnMeta;
      advPulse <= 1'b0;
      if (btnSync == debLevel) begin
        debCnt <= '0;
      end else if (debCnt == DEB_LAST) begin
        debLevel <= btnSync;
        debCnt   <= '0;
        advPulse <= btnSync;
      end else begin
        debCnt <= debCnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pageSel <= '0;
    else if (advPulse && (N_PAGES > 1))
      pageSel <= (pageSel == PAGE_LAST) ? '0 : pageSel + PW'(1);
  end

  assign page_sel = pageSel;

endmodule

// File: tb/tb_ssd_page_scanner.sv
module tb_ssd_page_scanner;

  localparam int ND    = 4;
  localparam int NP    = 3;
  localparam int SLOT  = 8;
  localparam int GUARD = 2;
  localparam int DEB   = 4;
  localparam int SCAN  = SLOT * ND;
  localparam int PW    = 2;
  localparam int W     = ND + 7 + 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NP*ND*4-1:0]  page_data = '0;
  logic                btn_page = 1'b0;
  logic                blank_lz = 1'b0;
  logic [ND-1:0]       dp_mask = '0;
  logic [ND-1:0]       anode;
  logic [6:0]          ssd_out;
  logic                dp;
  logic [PW-1:0]       page_sel;

  int checks = 0;
  int fails  = 0;
  logic [W-1:0] exp_q[$];

  // Reference state: cycles since reset release, the modelled snapshot and the expected page
  int              cyc;
  logic [ND*4-1:0] mSnap;
  int              mPageSel = 0;

  logic [6:0] font [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                            7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  ssd_page_scanner #(
    .N_DIGITS(ND), .N_PAGES(NP), .SLOT_CYCLES(SLOT),
    .GUARD_CYCLES(GUARD), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .page_data(page_data), .btn_page(btn_page),
    .blank_lz(blank_lz), .dp_mask(dp_mask), .anode(anode), .ssd_out(ssd_out),
    .dp(dp), .page_sel(page_sel)
  );

  // Snapshot model: the page is latched on the first edge after release and on every edge that starts a new scan
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc   <= 0;
      mSnap <= '0;
    end else begin
      cyc <= cyc + 1;
      if (cyc == 0 || (cyc + 1) % SCAN == 0)
        mSnap <= page_data[mPageSel*ND*4 +: ND*4];
    end
  end

  // Expected {anode, segments, dp} at position j of a scan
  function automatic logic [W-1:0] expect_at(input int j, input logic [ND*4-1:0] snap);
    int slot;
    int idx;
    logic [ND-1:0] an;
    logic [6:0] seg;
    logic d;
    slot = j % SLOT;
    idx  = j / SLOT;
    if (slot < GUARD) begin
      an  = '1;
      seg = 7'h7F;
      d   = 1'b1;
    end else begin
      an  = ~(ND'(1) << idx);
      if (blank_lz && idx != 0 && (snap >> (idx * 4)) == 0)
        seg = 7'h7F;
      else
        seg = font[snap[idx*4 +: 4]];
      d = ~dp_mask[idx];
    end
    return {an, seg, d};
  endfunction

  // ---------------- driver / scoreboard ----------------
  // Aligns to the next scan start and pushes one full scan of expectations.
  // It then pops and compares one entry each cycle. If chg_at >= 0, it
  // drives page_data = chg_val at that scan position.
  task automatic run_scan(input string name, input int chg_at, input logic [NP*ND*4-1:0] chg_val);
    int waited;
    logic [W-1:0] e;
    waited = 0;
    @(negedge clk);
    while (!(cyc > 0 && cyc % SCAN == 0) && waited < 2 * SCAN) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 2 * SCAN) begin
      checks++;
      fails++;
      $display("FAIL %s align: no scan start within %0d cycles", name, 2 * SCAN);
      return;
    end
    for (int j = 0; j < SCAN; j++) exp_q.push_back(expect_at(j, mSnap));
    for (int j = 0; j < SCAN; j++) begin
      if (j > 0) @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (anode !== e[W-1:8]) begin
        fails++;
        $display("FAIL %s anode pos %0d: got %h expected %h", name, j, anode, e[W-1:8]);
      end
      checks++;
      if (dp !== e[0]) begin
        fails++;
        $display("FAIL %s dp pos %0d: got %b expected %b", name, j, dp, e[0]);
      end
      if (e[W-1:8] != '1) begin
        checks++;
        if (ssd_out !== e[7:1]) begin
          fails++;
          $display("FAIL %s ssd_out pos %0d: got %h expected %h", name, j, ssd_out, e[7:1]);
        end
      end
      if (j == chg_at) page_data = chg_val;
    end
  endtask

  task automatic press(input int hold, input int rel);
    btn_page = 1'b1;
    repeat (hold) @(negedge clk);
    btn_page = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [ND-1:0] ea;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (anode !== 4'hF) begin fails++; $display("FAIL reset anode: got %h expected f", anode); end
    checks++; if (ssd_out !== 7'h7F) begin fails++; $display("FAIL reset ssd_out: got %h expected 7f", ssd_out); end
    checks++; if (dp !== 1'b1) begin fails++; $display("FAIL reset dp: got %b expected 1", dp); end
    checks++; if (page_sel !== 2'd0) begin fails++; $display("FAIL reset page_sel: got %0d expected 0", page_sel); end
    rst_n = 1'b1;
    for (int j = 0; j < 2 * SCAN; j++) begin
      if (j > 0) @(negedge clk);
      ea = ((j % SLOT) < GUARD) ? 4'hF : ~(4'h1 << ((j / SLOT) % ND));
      checks++;
      if (anode !== ea) begin
        fails++;
        $display("FAIL reset_scan anode cycle %0d: got %h expected %h", j, anode, ea);
      end
    end
  endtask

  task automatic test_decode();
    page_data = {32'h0, 16'h12AF};
    blank_lz  = 1'b0;
    dp_mask   = 4'b0100;
    run_scan("decode_12af", -1, '0);
    page_data = {32'h0, 16'h89CD};
    dp_mask   = 4'b1011;
    run_scan("decode_89cd", -1, '0);
  endtask

  task automatic test_blank();
    dp_mask   = 4'b0000;
    blank_lz  = 1'b1;
    page_data = {32'h0, 16'h0030};
    run_scan("blank_0030", -1, '0);
    page_data = {32'h0, 16'h0000};
    run_scan("blank_0000", -1, '0);
    page_data = {32'h0, 16'h0400};
    run_scan("blank_0400", -1, '0);
    blank_lz  = 1'b0;
    page_data = {32'h0, 16'h0000};
    run_scan("noblank_0000", -1, '0);
  endtask

  task automatic test_tear_free();
    blank_lz  = 1'b0;
    dp_mask   = 4'b1001;
    page_data = {32'h0, 16'h12AF};
    run_scan("tear_setup", -1, '0);
    // page_data changes while digit index 2 is active; this scan must stay on the old value
    run_scan("tear_hold", 2 * SLOT + 3, {32'h0, 16'h9C5E});
    run_scan("tear_new", -1, '0);
  endtask

  task automatic test_debounce();
    int changes;
    logic [PW-1:0] prev;
    logic [W-1:0] e;
    @(negedge clk);
    press(3, 15);
    checks++;
    if (page_sel !== PW'(mPageSel)) begin
      fails++;
      $display("FAIL glitch page_sel: got %0d expected %0d", page_sel, mPageSel);
    end
    // long hold: exactly one advance
    changes = 0;
    prev = page_sel;
    btn_page = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (page_sel !== prev) changes++;
      prev = page_sel;
    end
    mPageSel = (mPageSel + 1) % NP;
    checks++;
    if (page_sel !== PW'(mPageSel)) begin
      fails++;
      $display("FAIL hold page_sel: got %0d expected %0d", page_sel, mPageSel);
    end
    checks++;
    if (changes != 1) begin
      fails++;
      $display("FAIL hold advances: got %0d expected 1", changes);
    end
    btn_page = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (page_sel !== PW'(mPageSel)) begin
      fails++;
      $display("FAIL release page_sel: got %0d expected %0d", page_sel, mPageSel);
    end
    // clean presses with wrap: 1 -> 2 -> 0 -> 1
    for (int k = 0; k < 3; k++) begin
      mPageSel = (mPageSel + 1) % NP;
      exp_q.push_back(W'(mPageSel));
      press(12, 12);
      e = exp_q.pop_front();
      checks++;
      if (page_sel !== e[PW-1:0]) begin
        fails++;
        $display("FAIL press%0d page_sel: got %0d expected %0d", k, page_sel, e[PW-1:0]);
      end
    end
  endtask

  task automatic test_page_display();
    blank_lz  = 1'b0;
    dp_mask   = 4'b0010;
    page_data = {16'h8091, 16'hBCDE, 16'h4567};
    run_scan("page_sel1", -1, '0);
    mPageSel = (mPageSel + 1) % NP;
    press(12, 12);
    checks++;
    if (page_sel !== PW'(mPageSel)) begin
      fails++;
      $display("FAIL page_press page_sel: got %0d expected %0d", page_sel, mPageSel);
    end
    run_scan("page_sel2", -1, '0);
  endtask

  task automatic test_async_reset();
    int waited;
    waited = 0;
    while ((cyc % SLOT) != 4 && waited < 4 * SLOT) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (anode === 4'hF) begin
      fails++;
      $display("FAIL pre_reset anode: got %h expected one active digit", anode);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (anode !== 4'hF) begin fails++; $display("FAIL async anode: got %h expected f", anode); end
    checks++; if (ssd_out !== 7'h7F) begin fails++; $display("FAIL async ssd_out: got %h expected 7f", ssd_out); end
    checks++; if (dp !== 1'b1) begin fails++; $display("FAIL async dp: got %b expected 1", dp); end
    checks++; if (page_sel !== 2'd0) begin fails++; $display("FAIL async page_sel: got %0d expected 0", page_sel); end
    mPageSel = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (anode !== 4'hE) begin
      fails++;
      $display("FAIL post_reset anode: got %h expected e", anode);
    end
    checks++;
    if (page_sel !== 2'd0) begin
      fails++;
      $display("FAIL post_reset page_sel: got %0d expected 0", page_sel);
    end
    run_scan("post_reset_page0", -1, '0);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_blank();
    test_tear_free();
    test_debounce();
    test_page_display();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
